fetch_unit: RTL and testbench

//  IF stage: owns the PC, issues word reads on the instruction bus, and writes the if_id record consumed by decode.

---
 rtl/fetch_pkg.sv | 33 +++
 rtl/fetch_pc_gen.sv | 32 +++
 rtl/fetch_unit.sv | 162 ++++++++++++++++
 tb/tb_fetch_unit.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared IF-stage types: fetch FSM states, the if_id record handed to decode,
// and the instruction-bus request/response bundles.
package fetch_pkg;

  localparam logic [63:0] RESET_PC_DEF = 64'h8000_0000;
  localparam int          CNT_W_DEF    = 64;

  typedef enum logic [1:0] {
    REQ,
    WAIT,
    HOLD
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic        valid;
    logic [63:0] inst_counter;
    logic        misalign;
  } if_id_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;

endpackage

// File: rtl/fetch_pc_gen.sv
// Fetch PC register with next-pc selection: redirect, +4 advance, or hold.
module fetch_pc_gen
  import fetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect,
  input  logic [63:0] redirect_pc,
  input  logic        advance,
  output logic [63:0] pc
);

  logic [63:0] pc_n;

  always_comb begin
    pc_n = pc;
    if (redirect)
      pc_n = redirect_pc;
    else if (advance)
      pc_n = pc + 64'd4;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      pc <= RESET_PC;
    else
      pc <= pc_n;
  end

endmodule

// File: rtl/fetch_unit.sv
// IF stage: owns the PC, runs one-outstanding ibus reads, fills if_id.
// Optional FETCH_MISALIGN_EN reports misaligned redirect targets instead of fetching.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC = RESET_PC_DEF,
  parameter int          CNT_W    = CNT_W_DEF
) (
  input  logic        clk,
  input  logic        reset,
  output logic        ireq_valid,
  output logic [63:0] ireq_addr,
  input  logic        iresp_addr_ok,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  input  logic        stall,
  input  logic        redirect,
  input  logic [63:0] redirect_pc,
  output if_id_t      if_id_state
);

  fetch_state_t     state;
  fetch_state_t     state_n;
  logic             drop;
  logic             drop_n;
  logic             parked;
  logic             parked_n;
  logic [CNT_W-1:0] counter;
  logic [63:0]      pc;
  logic [63:0]      rpc;
  logic             mis;
  logic             pending;
  logic             take;
  logic             still_out;
  logic             load;
  ibus_req_t        req;
  ibus_resp_t       rsp;

  assign rsp = '{iresp_addr_ok, iresp_data_ok, iresp_data};

`ifdef FETCH_MISALIGN_EN
  assign rpc = redirect_pc;
  assign mis = redirect && (redirect_pc[1:0] != 2'b00);
`else
  logic unused_lo;
  assign unused_lo = ^redirect_pc[1:0];
  assign rpc = {redirect_pc[63:2], 2'b00};
  assign mis = 1'b0;
`endif

  // A request is in flight once accepted; HOLD can only carry one after a
  // misaligned redirect parked the stage with a response still owed.
  assign pending = (state == WAIT)
                 || (state == REQ && rsp.addr_ok)
                 || (state == HOLD && drop);
  assign take      = pending && rsp.data_ok;
  assign still_out = pending && !rsp.data_ok;

  always_comb begin
    state_n  = state;
    drop_n   = drop;
    parked_n = parked;
    load     = 1'b0;
    if (redirect) begin
      drop_n   = still_out;
      parked_n = mis;
      if (mis)
        state_n = HOLD;
      else if (still_out)
        state_n = WAIT;
      else
        state_n = REQ;
    end else begin
      if (take && drop)
        drop_n = 1'b0;
      unique case (state)
        REQ: begin
          if (rsp.addr_ok) begin
            if (rsp.data_ok) begin
              load    = 1'b1;
              state_n = stall ? HOLD : REQ;
            end else begin
              state_n = WAIT;
            end
          end
        end
        WAIT: begin
          if (rsp.data_ok) begin
            if (drop) begin
              state_n = REQ;
            end else begin
              load    = 1'b1;
              state_n = stall ? HOLD : REQ;
            end
          end
        end
        HOLD: begin
          if (!stall && !parked)
            state_n = REQ;
        end
        default: state_n = REQ;
      endcase
    end
  end

  fetch_pc_gen #(
    .RESET_PC(RESET_PC)
  ) u_pc_gen (
    .clk        (clk),
    .reset      (reset),
    .redirect   (redirect),
    .redirect_pc(rpc),
    .advance    (load),
    .pc         (pc)
  );

  // Reset is gated in so the bus sees no request while reset is held.
  assign req.valid  = (state == REQ) && !reset;
  assign req.addr   = pc;
  assign ireq_valid = req.valid;
  assign ireq_addr  = req.addr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= REQ;
      drop    <= 1'b0;
      parked  <= 1'b0;
      counter <= '0;
    end else begin
      state   <= state_n;
      drop    <= drop_n;
      parked  <= parked_n;
      if (load && !redirect)
        counter <= counter + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      if_id_state <= '0;
    end else if (redirect) begin
      if (mis) begin
        if_id_state.inst         <= 32'h0;
        if_id_state.inst_pc      <= rpc;
        if_id_state.valid        <= 1'b1;
        if_id_state.inst_counter <= 64'(counter);
        if_id_state.misalign     <= 1'b1;
      end else begin
        if_id_state.valid <= 1'b0;
      end
    end else if (load) begin
      if_id_state.inst         <= rsp.data;
      if_id_state.inst_pc      <= pc;
      if_id_state.valid        <= 1'b1;
      if_id_state.inst_counter <= 64'(counter);
      if_id_state.misalign     <= 1'b0;
    end else if (!stall) begin
      if_id_state.valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed-vector bench for fetch_unit; define FETCH_MISALIGN_EN for both
// DUT and bench to exercise misaligned redirects.
module tb_fetch_unit;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_addr_ok;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  logic        stall;
  logic        redirect;
  logic [63:0] redirect_pc;
  if_id_t      if_id_state;

  int pass_cnt = 0;
  int total_cnt = 0;

  fetch_unit dut (
    .clk          (clk),
    .reset        (reset),
    .ireq_valid   (ireq_valid),
    .ireq_addr    (ireq_addr),
    .iresp_addr_ok(iresp_addr_ok),
    .iresp_data_ok(iresp_data_ok),
    .iresp_data   (iresp_data),
    .stall        (stall),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .if_id_state  (if_id_state)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    iresp_addr_ok = 1'b0;
    iresp_data_ok = 1'b0;
    iresp_data    = 32'h0;
    stall         = 1'b0;
    redirect      = 1'b0;
    redirect_pc   = 64'h0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_in();
    step();
    step();
    total_cnt++;
    if (ireq_valid !== 1'b0)
      $display("FAIL rst_ireq_valid got %b want 0", ireq_valid);
    else pass_cnt++;
    total_cnt++;
    if (if_id_state !== '0)
      $display("FAIL rst_if_id got %h want 0", if_id_state);
    else pass_cnt++;
    reset = 1'b0;
    #1;
    total_cnt++;
    if (ireq_valid !== 1'b1 || ireq_addr !== 64'h8000_0000)
      $display("FAIL rst_first_req got %b/%h want 1/80000000",
               ireq_valid, ireq_addr);
    else pass_cnt++;
  endtask

  task automatic test_basic();
    iresp_addr_ok = 1'b1;
    step();
    iresp_addr_ok = 1'b0;
    total_cnt++;
    if (ireq_valid !== 1'b0)
      $display("FAIL basic_wait_novalid got %b want 0", ireq_valid);
    else pass_cnt++;
    iresp_data_ok = 1'b1;
    iresp_data    = 32'h1111_0013;
    step();
    iresp_data_ok = 1'b0;
    total_cnt++;
    if (if_id_state.valid !== 1'b1
        || if_id_state.inst_pc !== 64'h8000_0000
        || if_id_state.inst_counter !== 64'd0
        || if_id_state.inst !== 32'h1111_0013)
      $display("FAIL basic_load0 got %b/%h/%0d/%h want 1/80000000/0/11110013",
               if_id_state.valid, if_id_state.inst_pc,
               if_id_state.inst_counter, if_id_state.inst);
    else pass_cnt++;
    total_cnt++;
    if (ireq_valid !== 1'b1 || ireq_addr !== 64'h8000_0004)
      $display("FAIL basic_req1 got %b/%h want 1/80000004",
               ireq_valid, ireq_addr);
    else pass_cnt++;
    iresp_addr_ok = 1'b1;
    step();
    iresp_addr_ok = 1'b0;
    total_cnt++;
    if (if_id_state.valid !== 1'b0)
      $display("FAIL basic_bubble got %b want 0", if_id_state.valid);
    else pass_cnt++;
    // Second word lands with stall raised, so the stage parks in HOLD.
    iresp_data_ok = 1'b1;
    iresp_data    = 32'h2222_0013;
    stall         = 1'b1;
    step();
    iresp_data_ok = 1'b0;
    total_cnt++;
    if (if_id_state.valid !== 1'b1
        || if_id_state.inst_pc !== 64'h8000_0004
        || if_id_state.inst_counter !== 64'd1)
      $display("FAIL basic_load1 got %b/%h/%0d want 1/80000004/1",
               if_id_state.valid, if_id_state.inst_pc,
               if_id_state.inst_counter);
    else pass_cnt++;
  endtask

  task automatic test_stall();
    for (int i = 0; i < 3; i++) begin
      total_cnt++;
      if (ireq_valid !== 1'b0 || if_id_state.valid !== 1'b1
          || if_id_state.inst_pc !== 64'h8000_0004
          || if_id_state.inst_counter !== 64'd1
          || if_id_state.inst !== 32'h2222_0013)
        $display("FAIL stall_hold%0d got %b/%b/%h/%0d want 0/1/80000004/1",
                 i, ireq_valid, if_id_state.valid,
                 if_id_state.inst_pc, if_id_state.inst_counter);
      else pass_cnt++;
      step();
    end
    stall = 1'b0;
    step();
    total_cnt++;
    if (ireq_valid !== 1'b1 || ireq_addr !== 64'h8000_0008
        || if_id_state.valid !== 1'b0)
      $display("FAIL stall_release got %b/%h/%b want 1/80000008/0",
               ireq_valid, ireq_addr, if_id_state.valid);
    else pass_cnt++;
  endtask

  task automatic test_addr_wait();
    for (int i = 0; i < 4; i++) begin
      total_cnt++;
      if (ireq_valid !== 1'b1 || ireq_addr !== 64'h8000_0008)
        $display("FAIL addr_wait%0d got %b/%h want 1/80000008",
                 i, ireq_valid, ireq_addr);
      else pass_cnt++;
      step();
    end
    iresp_addr_ok = 1'b1;
    step();
    iresp_addr_ok = 1'b0;
    iresp_data_ok = 1'b1;
    iresp_data    = 32'h3333_0013;
    step();
    iresp_data_ok = 1'b0;
    total_cnt++;
    if (if_id_state.inst_pc !== 64'h8000_0008
        || if_id_state.inst_counter !== 64'd2
        || ireq_addr !== 64'h8000_000C)
      $display("FAIL addr_wait_load got %h/%0d/%h want 80000008/2/8000000c",
               if_id_state.inst_pc, if_id_state.inst_counter, ireq_addr);
    else pass_cnt++;
  endtask

  task automatic test_redirect_wait();
    iresp_addr_ok = 1'b1;
    step();
    iresp_addr_ok = 1'b0;
    redirect      = 1'b1;
    redirect_pc   = 64'h8000_1000;
    step();
    redirect = 1'b0;
    total_cnt++;
    if (if_id_state.valid !== 1'b0 || ireq_valid !== 1'b0)
      $display("FAIL redir_wait_drop got %b/%b want 0/0",
               if_id_state.valid, ireq_valid);
    else pass_cnt++;
    iresp_data_ok = 1'b1;
    iresp_data    = 32'hDEAD_BEEF;
    step();
    iresp_data_ok = 1'b0;
    total_cnt++;
    if (if_id_state.valid !== 1'b0 || ireq_valid !== 1'b1
        || ireq_addr !== 64'h8000_1000)
      $display("FAIL redir_wait_req got %b/%b/%h want 0/1/80001000",
               if_id_state.valid, ireq_valid, ireq_addr);
    else pass_cnt++;
    iresp_addr_ok = 1'b1;
    step();
    iresp_addr_ok = 1'b0;
    iresp_data_ok = 1'b1;
    iresp_data    = 32'h4444_0013;
    step();
    iresp_data_ok = 1'b0;
    total_cnt++;
    if (if_id_state.inst_pc !== 64'h8000_1000
        || if_id_state.inst_counter !== 64'd3
        || if_id_state.inst !== 32'h4444_0013)
      $display("FAIL redir_wait_load got %h/%0d/%h want 80001000/3/44440013",
               if_id_state.inst_pc, if_id_state.inst_counter,
               if_id_state.inst);
    else pass_cnt++;
  endtask

  task automatic test_redirect_data_stall();
    iresp_addr_ok = 1'b1;
    step();
    iresp_addr_ok = 1'b0;
    iresp_data_ok = 1'b1;
    iresp_data    = 32'hBAD0_0013;
    stall         = 1'b1;
    redirect      = 1'b1;
    redirect_pc   = 64'h8000_2000;
    step();
    idle_in();
    total_cnt++;
    if (if_id_state.valid !== 1'b0 || ireq_valid !== 1'b1
        || ireq_addr !== 64'h8000_2000)
      $display("FAIL redir_data_stall got %b/%b/%h want 0/1/80002000",
               if_id_state.valid, ireq_valid, ireq_addr);
    else pass_cnt++;
    iresp_addr_ok = 1'b1;
    step();
    iresp_addr_ok = 1'b0;
    iresp_data_ok = 1'b1;
    iresp_data    = 32'h5555_0013;
    step();
    iresp_data_ok = 1'b0;
    total_cnt++;
    if (if_id_state.inst_pc !== 64'h8000_2000
        || if_id_state.inst_counter !== 64'd4)
      $display("FAIL redir_data_stall_load got %h/%0d want 80002000/4",
               if_id_state.inst_pc, if_id_state.inst_counter);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    iresp_addr_ok = 1'b1;
    iresp_data_ok = 1'b1;
    iresp_data    = 32'h6666_0013;
    step();
    total_cnt++;
    if (if_id_state.inst_pc !== 64'h8000_2004
        || if_id_state.inst_counter !== 64'd5
        || ireq_addr !== 64'h8000_2008)
      $display("FAIL b2b_0 got %h/%0d/%h want 80002004/5/80002008",
               if_id_state.inst_pc, if_id_state.inst_counter, ireq_addr);
    else pass_cnt++;
    iresp_data = 32'h7777_0013;
    step();
    idle_in();
    total_cnt++;
    if (if_id_state.inst_pc !== 64'h8000_2008
        || if_id_state.inst_counter !== 64'd6
        || if_id_state.inst !== 32'h7777_0013)
      $display("FAIL b2b_1 got %h/%0d/%h want 80002008/6/77770013",
               if_id_state.inst_pc, if_id_state.inst_counter,
               if_id_state.inst);
    else pass_cnt++;
  endtask

  task automatic test_hold_redirect();
    iresp_addr_ok = 1'b1;
    step();
    iresp_addr_ok = 1'b0;
    iresp_data_ok = 1'b1;
    iresp_data    = 32'h8888_0013;
    stall         = 1'b1;
    step();
    iresp_data_ok = 1'b0;
    total_cnt++;
    if (if_id_state.valid !== 1'b1 || ireq_valid !== 1'b0
        || if_id_state.inst_counter !== 64'd7)
      $display("FAIL hold_enter got %b/%b/%0d want 1/0/7",
               if_id_state.valid, ireq_valid, if_id_state.inst_counter);
    else pass_cnt++;
    redirect    = 1'b1;
    redirect_pc = 64'h8000_4000;
    step();
    idle_in();
    total_cnt++;
    if (if_id_state.valid !== 1'b0 || ireq_valid !== 1'b1
        || ireq_addr !== 64'h8000_4000)
      $display("FAIL hold_redirect got %b/%b/%h want 0/1/80004000",
               if_id_state.valid, ireq_valid, ireq_addr);
    else pass_cnt++;
  endtask

  task automatic test_misalign();
    redirect    = 1'b1;
    redirect_pc = 64'h8000_3002;
    step();
    redirect = 1'b0;
`ifdef FETCH_MISALIGN_EN
    total_cnt++;
    if (ireq_valid !== 1'b0 || if_id_state.valid !== 1'b1
        || if_id_state.misalign !== 1'b1
        || if_id_state.inst_pc !== 64'h8000_3002
        || if_id_state.inst !== 32'h0)
      $display("FAIL misalign_emit got %b/%b/%b/%h/%h want 0/1/1/80003002/0",
               ireq_valid, if_id_state.valid, if_id_state.misalign,
               if_id_state.inst_pc, if_id_state.inst);
    else pass_cnt++;
    step();
    total_cnt++;
    if (ireq_valid !== 1'b0)
      $display("FAIL misalign_park got %b want 0", ireq_valid);
    else pass_cnt++;
`else
    total_cnt++;
    if (ireq_valid !== 1'b1 || ireq_addr !== 64'h8000_3000
        || if_id_state.misalign !== 1'b0)
      $display("FAIL misalign_forced got %b/%h/%b want 1/80003000/0",
               ireq_valid, ireq_addr, if_id_state.misalign);
    else pass_cnt++;
`endif
    redirect    = 1'b1;
    redirect_pc = 64'h8000_5000;
    step();
    redirect = 1'b0;
    total_cnt++;
    if (ireq_valid !== 1'b1 || ireq_addr !== 64'h8000_5000
        || if_id_state.valid !== 1'b0)
      $display("FAIL misalign_exit got %b/%h/%b want 1/80005000/0",
               ireq_valid, ireq_addr, if_id_state.valid);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    iresp_addr_ok = 1'b1;
    step();
    iresp_addr_ok = 1'b0;
    reset = 1'b1;
    #2;
    total_cnt++;
    if (ireq_valid !== 1'b0 || if_id_state !== '0)
      $display("FAIL rst_mid_clear got %b/%h want 0/0",
               ireq_valid, if_id_state);
    else pass_cnt++;
    step();
    reset = 1'b0;
    iresp_data_ok = 1'b1;
    iresp_data    = 32'hBAD1_0013;
    step();
    iresp_data_ok = 1'b0;
    total_cnt++;
    if (if_id_state.valid !== 1'b0 || ireq_valid !== 1'b1
        || ireq_addr !== 64'h8000_0000)
      $display("FAIL rst_mid_orphan got %b/%b/%h want 0/1/80000000",
               if_id_state.valid, ireq_valid, ireq_addr);
    else pass_cnt++;
    iresp_addr_ok = 1'b1;
    step();
    iresp_addr_ok = 1'b0;
    iresp_data_ok = 1'b1;
    iresp_data    = 32'h9999_0013;
    step();
    iresp_data_ok = 1'b0;
    total_cnt++;
    if (if_id_state.inst_pc !== 64'h8000_0000
        || if_id_state.inst_counter !== 64'd0
        || if_id_state.inst !== 32'h9999_0013)
      $display("FAIL rst_mid_refetch got %h/%0d/%h want 80000000/0/99990013",
               if_id_state.inst_pc, if_id_state.inst_counter,
               if_id_state.inst);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_addr_wait();
    test_redirect_wait();
    test_redirect_data_stall();
    test_back_to_back();
    test_hold_redirect();
    test_misalign();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
